// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between I-cache refills and D-cache
// refills/writebacks, sequencing one LINE_WORDS-beat burst per grant.
module mem_port_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic [DATA_W-1:0]             ic_rdata,
    output logic                          ic_rvalid,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [DATA_W-1:0]             dc_wdata,
    output logic [DATA_W-1:0]             dc_rdata,
    output logic                          dc_rvalid,
    output logic                          dc_done,
    output logic [$clog2(LINE_WORDS)-1:0] word_idx,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack
);

    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((LINE_WORDS * (DATA_W / 8)) - 1);
    localparam logic [IDX_W-1:0]  LAST_WORD   = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t             state, nextState;
    owner_t             owner, nextOwner;
    logic [IDX_W-1:0]   wordCount, nextWordCount;
    logic [ADDR_W-1:0]  lineAddr, nextLineAddr;
    logic               latchedWe, nextWe;
    logic               icDoneReg, dcDoneReg;
    logic               nextIcDone, nextDcDone;
    logic               inBurst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            wordCount <= '0;
            lineAddr  <= '0;
            latchedWe <= 1'b0;
            icDoneReg <= 1'b0;
            dcDoneReg <= 1'b0;
        end else begin
            state     <= nextState;
            owner     <= nextOwner;
            wordCount <= nextWordCount;
            lineAddr  <= nextLineAddr;
            latchedWe <= nextWe;
            icDoneReg <= nextIcDone;
            dcDoneReg <= nextDcDone;
        end
    end

    // D side wins ties: its miss stalls the whole pipeline, so I progress is blocked anyway.
    always_comb begin
        nextState     = state;
        nextOwner     = owner;
        nextWordCount = wordCount;
        nextLineAddr  = lineAddr;
        nextWe        = latchedWe;
        nextIcDone    = 1'b0;
        nextDcDone    = 1'b0;
        case (state)
            IDLE: begin
                nextWordCount = '0;
                if (dc_req) begin
                    nextState    = BURST;
                    nextOwner    = OWN_D;
                    nextLineAddr = dc_addr & ~OFFSET_MASK;
                    nextWe       = dc_we;
                end else if (ic_req) begin
                    nextState    = BURST;
                    nextOwner    = OWN_I;
                    nextLineAddr = ic_addr & ~OFFSET_MASK;
                    nextWe       = 1'b0;
                end
            end
            BURST: begin
                if (mem_ack) begin
                    if (wordCount == LAST_WORD) begin
                        nextWordCount = '0;
                        nextState     = DONE;
                        nextIcDone    = (owner == OWN_I);
                        nextDcDone    = (owner == OWN_D);
                    end else begin
                        nextWordCount = wordCount + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                nextState = IDLE;
                nextOwner = OWN_NONE;
            end
            default: begin
                nextState = IDLE;
                nextOwner = OWN_NONE;
            end
        endcase
    end

    // Read strobes pass mem_ack straight through so refill data needs no extra buffering.
    always_comb begin
        inBurst   = (state == BURST);
        mem_req   = inBurst;
        mem_we    = inBurst && latchedWe;
        mem_addr  = inBurst ? (lineAddr + (ADDR_W'(wordCount) << BYTE_SHIFT)) : '0;
        word_idx  = inBurst ? wordCount : '0;
        mem_wdata = (inBurst && (owner == OWN_D) && latchedWe) ? dc_wdata : '0;
        ic_rvalid = inBurst && (owner == OWN_I) && mem_ack;
        dc_rvalid = inBurst && (owner == OWN_D) && !latchedWe && mem_ack;
    end

    assign ic_rdata = mem_rdata;
    assign dc_rdata = mem_rdata;
    assign ic_done  = icDoneReg;
    assign dc_done  = dcDoneReg;

endmodule
